hazard_ctrl: RTL and testbench

- Pipeline control block that drives the pause/bubble inputs of the FI_ID, ID_EX, EX_MEM and MEM_WB stage registers and the PC.
- Detects load-use hazards in ID.
- Selects EX-stage operand forwarding.
- Runs a multi-cycle data-memory wait FSM that freezes the pipeline for MEM_LAT cycles per memory access.
- Keeps a saturating stall counter for performance debug.

---
 rtl/hazard_ctrl_if.sv | 39 +++
 rtl/hazard_ctrl.sv | 65 ++++++
 tb/tb_hazard_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side hazard status in, stage pause/bubble/forward controls out
interface hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic id_use_rs;
  logic id_use_rt;
  logic [4:0] ex_rs;
  logic [4:0] ex_rt;
  logic ex_regwe;
  logic [4:0] ex_dst;
  logic ex_is_load;
  logic mem_regwe;
  logic [4:0] mem_dst;
  logic mem_is_load;
  logic mem_access;
  logic wb_regwe;
  logic [4:0] wb_dst;
  logic pause_pc;
  logic pause_fi_id;
  logic pause_id_ex;
  logic pause_ex_mem;
  logic pause_mem_wb;
  logic bubble_id_ex;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_rs, ex_rt, ex_regwe, ex_dst, ex_is_load,
           mem_regwe, mem_dst, mem_is_load, mem_access, wb_regwe, wb_dst,
    input  pause_pc, pause_fi_id, pause_id_ex, pause_ex_mem, pause_mem_wb, bubble_id_ex,
           fwd_a, fwd_b, stall_cnt
  );
  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_rs, ex_rt, ex_regwe, ex_dst, ex_is_load,
           mem_regwe, mem_dst, mem_is_load, mem_access, wb_regwe, wb_dst,
    output pause_pc, pause_fi_id, pause_id_ex, pause_ex_mem, pause_mem_wb, bubble_id_ex,
           fwd_a, fwd_b, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use detection, EX forwarding select, data-memory wait FSM and stall counter
module hazard_ctrl #(
  parameter int MEM_LAT = 2,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [3:0] LAT = 4'(MEM_LAT);
  localparam bit HAS_WAIT = MEM_LAT != 0;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [CNT_W-1:0] stalls;
  logic ms, lu, pause, mem_ok, wb_ok;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      stalls <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (pause && stalls != '1) stalls <= stalls + 1'b1;
    end
  end
  // DONE gives the still-present access one free cycle so it cannot re-trigger
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    ms = 1'b0;
    case (state)
      IDLE: if (bus.mem_access && HAS_WAIT) begin
        ms = 1'b1;
        cnt_n = LAT - 4'd1;
        state_n = (LAT > 4'd1) ? BUSY : DONE;
      end
      BUSY: begin
        ms = 1'b1;
        cnt_n = cnt - 4'd1;
        state_n = (cnt == 4'd1) ? DONE : BUSY;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign lu = bus.ex_is_load & bus.ex_regwe & (bus.ex_dst != 5'd0) &
              ((bus.id_use_rs & (bus.id_rs == bus.ex_dst)) | (bus.id_use_rt & (bus.id_rt == bus.ex_dst)));
  assign pause = rst & (lu | ms);
  assign bus.pause_pc = pause;
  assign bus.pause_fi_id = pause;
  assign bus.pause_id_ex = rst & ms;
  assign bus.pause_ex_mem = rst & ms;
  assign bus.pause_mem_wb = rst & ms;
  assign bus.bubble_id_ex = rst & lu & !ms;
  // loads in MEM have no result yet, so only ALU results forward from EX_MEM
  assign mem_ok = bus.mem_regwe & !bus.mem_is_load & (bus.mem_dst != 5'd0);
  assign wb_ok = bus.wb_regwe & (bus.wb_dst != 5'd0);
  assign bus.fwd_a = !rst ? 2'b00 : (mem_ok && bus.mem_dst == bus.ex_rs) ? 2'b01 :
                     (wb_ok && bus.wb_dst == bus.ex_rs) ? 2'b10 : 2'b00;
  assign bus.fwd_b = !rst ? 2'b00 : (mem_ok && bus.mem_dst == bus.ex_rt) ? 2'b01 :
                     (wb_ok && bus.wb_dst == bus.ex_rt) ? 2'b10 : 2'b00;
  assign bus.stall_cnt = stalls;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors against three latencies (2, 0, 4) with a queue-based scoreboard
module tb_hazard_ctrl;
  typedef struct {
    string name;
    int sel;
    logic [25:0] v;
  } exp_t;
  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] LU = 6'b110001;
  localparam logic [5:0] MS = 6'b111110;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
  logic id_use_rs, id_use_rt, ex_regwe, ex_is_load, mem_regwe, mem_is_load, mem_access, wb_regwe;
  logic [25:0] obs [3];
  exp_t q [$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  hazard_ctrl_if #(.CNT_W(16)) bus [3] ();
  for (genvar i = 0; i < 3; i++) begin : g_dut
    assign bus[i].id_rs = id_rs;
    assign bus[i].id_rt = id_rt;
    assign bus[i].id_use_rs = id_use_rs;
    assign bus[i].id_use_rt = id_use_rt;
    assign bus[i].ex_rs = ex_rs;
    assign bus[i].ex_rt = ex_rt;
    assign bus[i].ex_regwe = ex_regwe;
    assign bus[i].ex_dst = ex_dst;
    assign bus[i].ex_is_load = ex_is_load;
    assign bus[i].mem_regwe = mem_regwe;
    assign bus[i].mem_dst = mem_dst;
    assign bus[i].mem_is_load = mem_is_load;
    assign bus[i].mem_access = mem_access;
    assign bus[i].wb_regwe = wb_regwe;
    assign bus[i].wb_dst = wb_dst;
    hazard_ctrl #(.MEM_LAT(i == 0 ? 2 : i == 1 ? 0 : 4), .CNT_W(16)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus[i])
    );
    assign obs[i] = {bus[i].pause_pc, bus[i].pause_fi_id, bus[i].pause_id_ex, bus[i].pause_ex_mem,
                     bus[i].pause_mem_wb, bus[i].bubble_id_ex, bus[i].fwd_a, bus[i].fwd_b, bus[i].stall_cnt};
  end
  always @(negedge clk) begin
    while (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if (obs[e.sel] !== e.v) begin
        errors++;
        $display("FAIL %s dut%0d: got ctl=%b fa=%b fb=%b cnt=%0d, expected ctl=%b fa=%b fb=%b cnt=%0d",
                 e.name, e.sel, obs[e.sel][25:20], obs[e.sel][19:18], obs[e.sel][17:16], obs[e.sel][15:0],
                 e.v[25:20], e.v[19:18], e.v[17:16], e.v[15:0]);
      end
    end
  end
  task automatic want(input string n, input int s, input logic [5:0] c, input logic [1:0] a,
                      input logic [1:0] b, input logic [15:0] sc);
    q.push_back('{n, s, {c, a, b, sc}});
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear();
    {id_rs, id_rt, ex_rs, ex_rt, ex_dst, mem_dst, wb_dst} = '0;
    {id_use_rs, id_use_rt, ex_regwe, ex_is_load, mem_regwe, mem_is_load, mem_access, wb_regwe} = '0;
  endtask
  task automatic set_lu_rs();
    ex_is_load = 1; ex_regwe = 1; ex_dst = 8; id_rs = 8; id_use_rs = 1;
  endtask
  initial begin
    rst = 0;
    clear();
    set_lu_rs();
    mem_access = 1;
    mem_regwe = 1; mem_dst = 5; ex_rs = 5;
    tick();
    want("reset_gates", 0, NONE, 2'b00, 2'b00, 0);
    want("reset_gates", 2, NONE, 2'b00, 2'b00, 0);
    tick();
    clear();
    rst = 1;
    want("idle_after_reset", 0, NONE, 2'b00, 2'b00, 0);
    tick();
    set_lu_rs();
    want("lu_rs", 0, LU, 2'b00, 2'b00, 0);
    tick();
    clear();
    want("lu_one_cycle", 0, NONE, 2'b00, 2'b00, 1);
    want("lu_cnt_lat0", 1, NONE, 2'b00, 2'b00, 1);
    tick();
    ex_is_load = 1; ex_regwe = 1; ex_dst = 0; id_rs = 0; id_use_rs = 1;
    want("lu_r0_ignored", 0, NONE, 2'b00, 2'b00, 1);
    tick();
    clear();
    ex_is_load = 1; ex_regwe = 1; ex_dst = 8; id_rt = 8; id_use_rt = 1; id_rs = 8;
    want("lu_rt", 0, LU, 2'b00, 2'b00, 1);
    tick();
    clear();
    want("lu_rt_done", 0, NONE, 2'b00, 2'b00, 2);
    tick();
    mem_access = 1;
    want("mem_c0", 0, MS, 2'b00, 2'b00, 2);
    want("mem_lat0_c0", 1, NONE, 2'b00, 2'b00, 2);
    tick();
    want("mem_c1", 0, MS, 2'b00, 2'b00, 3);
    want("mem_lat0_c1", 1, NONE, 2'b00, 2'b00, 2);
    tick();
    want("mem_c2_done", 0, NONE, 2'b00, 2'b00, 4);
    tick();
    clear();
    want("mem_after", 0, NONE, 2'b00, 2'b00, 4);
    tick();
    set_lu_rs();
    mem_access = 1;
    want("prio_c0", 0, MS, 2'b00, 2'b00, 4);
    want("prio_lat0_lu", 1, LU, 2'b00, 2'b00, 2);
    tick();
    want("prio_c1", 0, MS, 2'b00, 2'b00, 5);
    tick();
    want("prio_c2_bubble", 0, LU, 2'b00, 2'b00, 6);
    tick();
    clear();
    want("prio_end", 0, NONE, 2'b00, 2'b00, 7);
    want("prio_lat0_end", 1, NONE, 2'b00, 2'b00, 5);
    tick();
    mem_access = 1;
    want("b2b_c0", 0, MS, 2'b00, 2'b00, 7);
    tick();
    want("b2b_c1", 0, MS, 2'b00, 2'b00, 8);
    tick();
    want("b2b_done", 0, NONE, 2'b00, 2'b00, 9);
    tick();
    want("b2b_restart", 0, MS, 2'b00, 2'b00, 9);
    tick();
    want("b2b_c4", 0, MS, 2'b00, 2'b00, 10);
    tick();
    want("b2b_done2", 0, NONE, 2'b00, 2'b00, 11);
    tick();
    clear();
    mem_access = 1;
    ex_rs = 5; ex_rt = 5; mem_regwe = 1; mem_dst = 5; wb_regwe = 1; wb_dst = 5;
    want("fwd_mem_prio", 0, MS, 2'b01, 2'b01, 11);
    tick();
    mem_is_load = 1;
    want("fwd_load_to_wb", 0, MS, 2'b10, 2'b10, 12);
    tick();
    mem_regwe = 0; wb_dst = 0;
    want("fwd_none", 0, NONE, 2'b00, 2'b00, 13);
    tick();
    clear();
    ex_rs = 5; ex_rt = 6; mem_regwe = 1; mem_dst = 5; wb_regwe = 1; wb_dst = 6;
    want("fwd_split", 0, NONE, 2'b01, 2'b10, 13);
    tick();
    ex_rs = 0; ex_rt = 0; mem_dst = 0; wb_dst = 0;
    want("fwd_r0", 0, NONE, 2'b00, 2'b00, 13);
    tick();
    clear();
    rst = 0;
    want("reset2", 0, NONE, 2'b00, 2'b00, 0);
    tick();
    rst = 1;
    mem_access = 1;
    want("busy4_c0", 2, MS, 2'b00, 2'b00, 0);
    want("busy2_c0", 0, MS, 2'b00, 2'b00, 0);
    tick();
    want("busy4_c1", 2, MS, 2'b00, 2'b00, 1);
    @(negedge clk);
    #1;
    rst = 0;
    tick();
    want("busy4_reset", 2, NONE, 2'b00, 2'b00, 0);
    tick();
    rst = 1;
    want("busy4_fresh0", 2, MS, 2'b00, 2'b00, 0);
    tick();
    want("busy4_fresh1", 2, MS, 2'b00, 2'b00, 1);
    tick();
    want("busy4_fresh2", 2, MS, 2'b00, 2'b00, 2);
    tick();
    want("busy4_fresh3", 2, MS, 2'b00, 2'b00, 3);
    tick();
    want("busy4_done", 2, NONE, 2'b00, 2'b00, 4);
    tick();
    clear();
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
